// File: rtl/pipelined_signed_addsub_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_signed_addsub_pkg
// Shared definitions for the pipelined signed add/subtract unit:
//   - OP_ADD / OP_SUB encodings of the op input
//   - sat_limit(): most-positive / most-negative two's complement constant
//     for a given width (returned in a MAX_WIDTH container, low bits valid)
//   - split_ok(): legality of splitting WIDTH bits into STAGES equal slices
// -----------------------------------------------------------------------------
package pipelined_signed_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest datapath the saturation helper can describe.
    localparam int unsigned MAX_WIDTH = 32'd64;

    // Saturation constant for a signed value of 'width' bits:
    // negative=0 -> 011..1, negative=1 -> 100..0. Bits above width are zero.
    function automatic logic [MAX_WIDTH-1:0] sat_limit(input int unsigned width,
                                                       input logic        negative);
        logic [MAX_WIDTH-1:0] v;
        v = {MAX_WIDTH{1'b0}};
        for (int unsigned i = 32'd0; i < MAX_WIDTH; i++) begin
            if (i + 32'd1 < width) begin
                v[i] = ~negative;
            end else if (i + 32'd1 == width) begin
                v[i] = negative;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // A split is legal when there is at least one stage, the width fits the
    // helper container, and every slice gets the same number of bits.
    function automatic bit split_ok(input int unsigned width, input int unsigned stages);
        bit ok;
        if (stages == 32'd0 || width == 32'd0 || width > MAX_WIDTH) begin
            ok = 1'b0;
        end else begin
            ok = ((width % stages) == 32'd0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/pipelined_signed_addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// Combinational SW-bit adder used as one slice of the pipelined carry chain.
// Ports:
//   a_i, b_i  : SW-bit operand chunks (b already inverted for subtract)
//   c_i       : carry into bit 0 of the slice
//   s_o       : SW-bit sum chunk
//   c_o       : carry out of the slice MSB
//   c_msb_o   : carry into the slice MSB (signed overflow detection)
// -----------------------------------------------------------------------------
module addsub_slice
    import pipelined_signed_addsub_pkg::*;
#(
    parameter int SW = 32'd4
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          c_i,
    output logic [SW-1:0] s_o,
    output logic          c_o,
    output logic          c_msb_o
);

    logic [SW:0] total_s;

    // One wide add; the carry into the MSB is recovered from the MSB sum bit,
    // which avoids a special case for one-bit slices.
    always_comb begin
        total_s = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};
        s_o     = total_s[SW-1:0];
        c_o     = total_s[SW];
        c_msb_o = a_i[SW-1] ^ b_i[SW-1] ^ total_s[SW-1];
    end

endmodule

// File: rtl/pipelined_signed_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_signed_addsub
// Pipelined signed add/subtract with wrap/saturate modes, valid/ready stream
// handshake and a saturating overflow event counter. Latency = STAGES cycles.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = global advance)
//   a, b, cin, op, sat  : operands, carry/borrow in, 0=add 1=sub, 1=saturate
//   out_valid/out_ready : output handshake
//   sum, cout, overflow : result, raw carry out of MSB, signed overflow
//   ovf_count, clr_count: overflow event counter and its clear
// -----------------------------------------------------------------------------
module pipelined_signed_addsub
    import pipelined_signed_addsub_pkg::*;
#(
    parameter int WIDTH   = 32'd8,
    parameter int STAGES  = 32'd2,
    parameter int COUNT_W = 32'd8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic               op,
    input  logic               sat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic               overflow,
    output logic [COUNT_W-1:0] ovf_count,
    input  logic               clr_count
);

    localparam int SW = WIDTH / STAGES;
    localparam logic [MAX_WIDTH-1:0] SAT_POS_FULL = sat_limit(WIDTH, 1'b0);
    localparam logic [MAX_WIDTH-1:0] SAT_NEG_FULL = sat_limit(WIDTH, 1'b1);
    localparam logic [WIDTH-1:0]     SAT_POS      = SAT_POS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_NEG      = SAT_NEG_FULL[WIDTH-1:0];
    localparam logic [COUNT_W-1:0]   COUNT_MAX    = {COUNT_W{1'b1}};

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipelined_signed_addsub: WIDTH must be a multiple of STAGES (STAGES >= 1, WIDTH <= 64)");
    end

    logic               adv_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic               carry0_s;

    // Per-slice adder connections.
    logic [STAGES-1:0][SW-1:0] sl_a_s;
    logic [STAGES-1:0][SW-1:0] sl_b_s;
    logic [STAGES-1:0][SW-1:0] sl_sum_s;
    logic [STAGES-1:0]         sl_cin_s;
    logic [STAGES-1:0]         sl_cout_s;
    logic [STAGES-1:0]         sl_cmsb_s;

    // Values presented to the output register by the final slice.
    logic               fin_vld_s;
    logic               fin_sat_s;
    logic               fin_amsb_s;
    logic               fin_ovf_s;
    logic [WIDTH-1:0]   fin_raw_s;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               cout_q,      cout_d;
    logic               ovf_q,       ovf_d;
    logic [COUNT_W-1:0] cnt_q,       cnt_d;

    // The whole pipe moves together; a stalled output freezes every stage.
    assign adv_s    = !out_valid_q || out_ready;
    assign in_ready = adv_s;

    // Subtract is a + ~b + ~borrow.
    assign b_eff_s  = (op == OP_SUB) ? ~b : b;
    assign carry0_s = (op == OP_SUB) ? ~cin : cin;

    assign sl_a_s[0]   = a[SW-1:0];
    assign sl_b_s[0]   = b_eff_s[SW-1:0];
    assign sl_cin_s[0] = carry0_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(.SW(SW)) u_slice (
            .a_i     (sl_a_s[k]),
            .b_i     (sl_b_s[k]),
            .c_i     (sl_cin_s[k]),
            .s_o     (sl_sum_s[k]),
            .c_o     (sl_cout_s[k]),
            .c_msb_o (sl_cmsb_s[k])
        );
    end

    // Intermediate registers after slices 0..STAGES-2. Each holds the result
    // bits finished so far and the operand bits not yet added, so the
    // operands shrink by one slice per stage while the result grows.
    for (genvar j = 0; j < STAGES - 1; j++) begin : g_mid
        localparam int DW = (j + 1) * SW;
        localparam int RW = WIDTH - DW;

        logic          vld_q,   vld_d;
        logic          sat_q,   sat_d;
        logic          amsb_q,  amsb_d;
        logic          carry_q, carry_d;
        logic [DW-1:0] sum_q,   sum_d;
        logic [RW-1:0] arem_q,  arem_d;
        logic [RW-1:0] brem_q,  brem_d;

        if (j == 0) begin : g_head
            assign vld_d   = in_valid;
            assign sat_d   = sat;
            assign amsb_d  = a[WIDTH-1];
            assign sum_d   = sl_sum_s[0];
            assign arem_d  = a[WIDTH-1:SW];
            assign brem_d  = b_eff_s[WIDTH-1:SW];
        end else begin : g_body
            assign vld_d   = g_mid[j-1].vld_q;
            assign sat_d   = g_mid[j-1].sat_q;
            assign amsb_d  = g_mid[j-1].amsb_q;
            assign sum_d   = {sl_sum_s[j], g_mid[j-1].sum_q};
            assign arem_d  = g_mid[j-1].arem_q[WIDTH-j*SW-1:SW];
            assign brem_d  = g_mid[j-1].brem_q[WIDTH-j*SW-1:SW];
        end
        assign carry_d = sl_cout_s[j];

        // Next slice works on the lowest remaining chunk and this carry.
        assign sl_a_s[j+1]   = arem_q[SW-1:0];
        assign sl_b_s[j+1]   = brem_q[SW-1:0];
        assign sl_cin_s[j+1] = carry_q;

        // Stage register: cleared on reset, loaded on advance, else held.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q   <= 1'b0;
                sat_q   <= 1'b0;
                amsb_q  <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= {DW{1'b0}};
                arem_q  <= {RW{1'b0}};
                brem_q  <= {RW{1'b0}};
            end else if (adv_s) begin
                vld_q   <= vld_d;
                sat_q   <= sat_d;
                amsb_q  <= amsb_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
                arem_q  <= arem_d;
                brem_q  <= brem_d;
            end else begin
                vld_q   <= vld_q;
                sat_q   <= sat_q;
                amsb_q  <= amsb_q;
                carry_q <= carry_q;
                sum_q   <= sum_q;
                arem_q  <= arem_q;
                brem_q  <= brem_q;
            end
        end
    end

    if (STAGES == 1) begin : g_fin_direct
        assign fin_vld_s  = in_valid;
        assign fin_sat_s  = sat;
        assign fin_amsb_s = a[WIDTH-1];
        assign fin_raw_s  = sl_sum_s[0];
    end else begin : g_fin_pipe
        assign fin_vld_s  = g_mid[STAGES-2].vld_q;
        assign fin_sat_s  = g_mid[STAGES-2].sat_q;
        assign fin_amsb_s = g_mid[STAGES-2].amsb_q;
        assign fin_raw_s  = {sl_sum_s[STAGES-1], g_mid[STAGES-2].sum_q};
    end

    assign fin_ovf_s = sl_cmsb_s[STAGES-1] ^ sl_cout_s[STAGES-1];

    // Output stage next-state: saturate on overflow, cout/overflow stay raw.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (adv_s) begin
            out_valid_d = fin_vld_s;
            cout_d      = sl_cout_s[STAGES-1];
            ovf_d       = fin_ovf_s;
            if (fin_sat_s && fin_ovf_s) begin
                sum_d = fin_amsb_s ? SAT_NEG : SAT_POS;
            end else begin
                sum_d = fin_raw_s;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Overflow counter next-state: clear beats increment; sticks at max.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = {COUNT_W{1'b0}};
        end else if (out_valid_q && out_ready && ovf_q && (cnt_q != COUNT_MAX)) begin
            cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= {COUNT_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_pipelined_signed_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_signed_addsub
// Self-checking bench: directed vectors with hand-computed results, a
// back-pressure burst, counter clear/saturation, reset mid-flight and a
// randomized phase. Expected results come from a transaction-level model
// (signed integer arithmetic plus a queue of in-flight results).
// A second instance with COUNT_W=2 checks counter saturation.
// -----------------------------------------------------------------------------
module tb_pipelined_signed_addsub;

    localparam int W  = 8;
    localparam int ST = 2;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = 8'h00;
    logic [W-1:0] b = 8'h00;
    logic         cin = 1'b0;
    logic         op = 1'b0;
    logic         sat = 1'b0;
    logic         out_ready = 1'b1;
    logic         clr_count = 1'b0;

    logic          in_ready, out_valid, cout, overflow;
    logic [W-1:0]  sum;
    logic [CW-1:0] ovf_count;
    logic          in_ready2, out_valid2, cout2, overflow2;
    logic [W-1:0]  sum2;
    logic [1:0]    ovf_count2;

    always #5 clk = ~clk;

    pipelined_signed_addsub #(.WIDTH(W), .STAGES(ST), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .overflow(overflow), .ovf_count(ovf_count), .clr_count(clr_count)
    );

    pipelined_signed_addsub #(.WIDTH(W), .STAGES(ST), .COUNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .cin(cin), .op(op), .sat(sat),
        .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .cout(cout2),
        .overflow(overflow2), .ovf_count(ovf_count2), .clr_count(clr_count)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           age;   // clock advances seen since acceptance
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt_m    = 0;
    int   cnt2_m   = 0;
    int   popped   = 0;
    bit   last_acc = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Result from plain signed arithmetic on the true mathematical value.
    function automatic exp_t ref_model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                       input logic vc, input logic vo, input logic vs);
        exp_t e;
        int   sa, sb, ua, ub, r;
        sa = int'($signed(va));
        sb = int'($signed(vb));
        ua = int'(va);
        ub = int'(vb);
        if (vo == 1'b0) begin
            r      = sa + sb + int'(vc);
            e.cout = ((ua + ub + int'(vc)) >= 256);
        end else begin
            r      = sa - sb - int'(vc);
            e.cout = ((ua - ub - int'(vc)) >= 0);
        end
        e.ovf = (r > 127) || (r < -128);
        if (e.ovf && vs) e.sum = (r > 127) ? 8'h7F : 8'h80;
        else             e.sum = r[7:0];
        e.age = 0;
        return e;
    endfunction

    // One clock: check outputs on the falling edge, update the model for the
    // coming rising edge, return just after that edge.
    task automatic step();
        bit   exp_valid, adv;
        exp_t e;
        @(negedge clk);
        exp_valid = (q.size() > 0) && (q[0].age >= ST);
        check_eq("out_valid",  out_valid,  exp_valid);
        check_eq("out_valid2", out_valid2, exp_valid);
        check_eq("in_ready",   in_ready,   !exp_valid || out_ready);
        check_eq("in_ready2",  in_ready2,  !exp_valid || out_ready);
        check_eq("ovf_count",  ovf_count,  cnt_m);
        check_eq("ovf_count2", ovf_count2, cnt2_m);
        if (exp_valid) begin
            check_eq("sum",       sum,       q[0].sum);
            check_eq("cout",      cout,      q[0].cout);
            check_eq("overflow",  overflow,  q[0].ovf);
            check_eq("sum2",      sum2,      q[0].sum);
            check_eq("cout2",     cout2,     q[0].cout);
            check_eq("overflow2", overflow2, q[0].ovf);
        end
        adv      = !exp_valid || out_ready;
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
            cnt_m  = 0;
            cnt2_m = 0;
        end else begin
            if (clr_count) begin
                cnt_m  = 0;
                cnt2_m = 0;
            end else if (exp_valid && out_ready && q[0].ovf) begin
                if (cnt_m  < 255) cnt_m++;
                if (cnt2_m < 3)   cnt2_m++;
            end
            if (exp_valid && out_ready) begin
                void'(q.pop_front());
                popped++;
            end
            if (adv) begin
                for (int i = 0; i < q.size(); i++) begin
                    e = q[i];
                    e.age = e.age + 1;
                    q[i] = e;
                end
                if (in_valid) begin
                    e = ref_model(a, b, cin, op, sat);
                    e.age = 1;
                    q.push_back(e);
                    last_acc = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single transaction into an empty pipe, with hand-computed expectations.
    task automatic run_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                           input logic vo, input logic vs,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        int waited;
        in_valid = 1'b1; a = va; b = vb; cin = vc; op = vo; sat = vs;
        step();
        in_valid = 1'b0;
        check_eq("vec_accept", last_acc, 1'b1);
        waited = 1;
        while (!out_valid && waited < 10) begin
            step();
            waited++;
        end
        check_eq("vec_latency", waited, ST);
        check_eq("vec_sum",  sum,      es);
        check_eq("vec_cout", cout,     ec);
        check_eq("vec_ovf",  overflow, eo);
    endtask

    task automatic drain(input string tag);
        int n;
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        while (q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        check_eq(tag, q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time limit expired");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ba[6];
        logic [W-1:0] bb[6];
        logic         bo[6];
        int           idx, cyc, pop0;

        repeat (2) @(posedge clk);
        #1;
        step();
        check_eq("rst_sum",      sum,       8'h00);
        check_eq("rst_cout",     cout,      1'b0);
        check_eq("rst_ovf",      overflow,  1'b0);
        check_eq("rst_count",    ovf_count, 8'h00);
        rst = 1'b0;
        step();

        // Overflowing adds, wrap then saturate.
        run_vec(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_vec(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        run_vec(8'h80, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        step();
        check_eq("count_3", ovf_count, 8'd3);
        run_vec(8'h80, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
        // Subtracts.
        run_vec(8'h0A, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        run_vec(8'hAA, 8'h34, 1'b0, 1'b1, 1'b0, 8'h76, 1'b1, 1'b1);
        run_vec(8'hAA, 8'h34, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
        run_vec(8'h03, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check_eq("count_6",     ovf_count,  8'd6);
        check_eq("count2_sat",  ovf_count2, 2'd3);

        // Clear wins over a simultaneous overflowing accept.
        in_valid = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0; op = 1'b0; sat = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        check_eq("clr_valid", out_valid, 1'b1);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        check_eq("clr_count",  ovf_count,  8'd0);
        check_eq("clr_count2", ovf_count2, 2'd0);

        // Back-pressure burst of six with a three-cycle stall.
        for (int i = 0; i < 6; i++) begin
            ba[i] = 8'($urandom);
            bb[i] = 8'($urandom);
            bo[i] = 1'($urandom);
        end
        pop0 = popped; idx = 0; cyc = 0;
        while (idx < 6 && cyc < 40) begin
            in_valid = 1'b1; a = ba[idx]; b = bb[idx]; op = bo[idx];
            cin = 1'b0; sat = idx[0];
            out_ready = !(cyc >= 3 && cyc < 6);
            if (cyc == 4) begin
                #1;
                check_eq("bp_stall_ready", in_ready, 1'b0);
            end
            step();
            if (last_acc) idx++;
            cyc++;
        end
        check_eq("bp_sent", idx, 6);
        drain("bp_drain");
        check_eq("bp_popped", popped - pop0, 6);

        // Randomized traffic with random back-pressure and occasional clears.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom);
            cin       = 1'($urandom);
            op        = 1'($urandom);
            sat       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_count = ($urandom_range(0, 19) == 0);
            step();
        end
        clr_count = 1'b0;
        drain("rand_drain");

        // Reset with two transactions in flight.
        in_valid = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0; op = 1'b0; sat = 1'b0;
        step();
        a = 8'h80; b = 8'hFF;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check_eq("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        step();
        check_eq("rst_mid_valid", out_valid, 1'b0);
        check_eq("rst_mid_count", ovf_count, 8'd0);
        rst = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            check_eq("no_stale", out_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
